// File: rtl/unidade_de_controle.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback
// sequencing for the PC / register bank / ULA / data memory datapath.
module unidade_de_controle #(
  parameter int ULA_TIMEOUT = 8
) (
  input  logic        Clock_in,
  input  logic        Signal_reset,
  input  logic [31:0] MEM_INS_Q,
  input  logic        ULA_OUT_Ready,
  input  logic        ULA_FLAG_Zero,
  input  logic        ULA_FLAG_Signal,
  input  logic        ULA_FLAG_Carry_out,
  input  logic        ULA_FLAG_Overflow,
  output logic        PC_Signal_write,
  output logic [1:0]  PC_Sel,
  output logic [3:0]  B_R_Read_1,
  output logic [3:0]  B_R_Read_2,
  output logic [3:0]  B_R_Address_to_write,
  output logic        B_R_Signal_write,
  output logic        B_R_Signal_read,
  output logic [1:0]  WB_Sel,
  output logic        ULA_SrcA_Sel,
  output logic        ULA_SrcB_Sel,
  output logic        ULA_Enable,
  output logic [4:0]  UNIDADE_CONTR_ULA_OPULA,
  output logic [15:0] EXTENSOR_DE_SINAL_IN,
  output logic        MEM_DATA_WE,
  output logic        Halted,
  output logic        Illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_MEMW   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [4:0] OPULA_ADD = 5'd0;

  localparam int TW = $clog2(ULA_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_MAX = TW'(ULA_TIMEOUT - 1);

  logic [2:0]    state, state_n;
  logic [31:0]   ir, instr;
  logic [3:0]    flags;
  logic          illegal_q;
  logic [TW-1:0] tcnt;

  logic [2:0] opcode;
  logic [1:0] opes;
  logic is_r, is_const, is_mem, is_br, is_brr, is_halt;
  logic is_addi, is_store, is_load, ill_dec, go_wb;
  logic flag_sel, taken, timeout;
  logic unused_bits;

  // During DECODE the fresh word is decoded directly so reads start early
  assign instr    = (state == S_DECODE) ? MEM_INS_Q : ir;
  assign opcode   = instr[31:29];
  assign opes     = instr[28:27];
  assign is_r     = opcode == 3'b000;
  assign is_const = opcode == 3'b001;
  assign is_mem   = opcode == 3'b010;
  assign is_br    = opcode == 3'b011;
  assign is_brr   = opcode == 3'b100;
  assign is_halt  = opcode == 3'b111;
  assign is_addi  = is_const && opes == 2'b10;
  assign is_store = is_mem && instr[28];
  assign is_load  = is_mem && !instr[28];
  assign ill_dec  = opcode == 3'b101 || opcode == 3'b110
                 || (is_const && opes == 2'b11);
  assign go_wb    = (is_const && !opes[1]) || is_brr;
  assign timeout  = !ULA_OUT_Ready && tcnt == T_MAX;
  assign unused_bits = instr[16];

  always_comb begin
    flag_sel = 1'b0;
    case (instr[26:25])
      2'b00:   flag_sel = flags[3];
      2'b01:   flag_sel = flags[2];
      2'b10:   flag_sel = flags[1];
      default: flag_sel = flags[0];
    endcase
  end

  assign taken = is_br
    && (instr[28] || (!instr[27] && (flag_sel ^ instr[24])));

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          ill_dec: state_n = S_HALT;
          is_halt: state_n = S_HALT;
          go_wb:   state_n = S_WB;
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (ULA_OUT_Ready)
          state_n = is_mem ? S_MEM : S_WB;
        else if (timeout)
          state_n = S_HALT;
      end
      S_MEM:   state_n = is_store ? S_WB : S_MEMW;
      S_MEMW:  state_n = S_WB;
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock_in) begin
    if (Signal_reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      flags     <= '0;
      illegal_q <= 1'b0;
      tcnt      <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE)
        ir <= MEM_INS_Q;
      if (state == S_DECODE && ill_dec)
        illegal_q <= 1'b1;
      if (state == S_EXEC && timeout)
        illegal_q <= 1'b1;
      if (state == S_EXEC && !ULA_OUT_Ready)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (state == S_EXEC && ULA_OUT_Ready && (is_r || is_addi))
        flags <= {ULA_FLAG_Zero, ULA_FLAG_Signal,
                  ULA_FLAG_Carry_out, ULA_FLAG_Overflow};
    end
  end

  always_comb begin
    B_R_Read_1           = 4'd0;
    B_R_Read_2           = 4'd0;
    B_R_Address_to_write = 4'd0;
    unique case (1'b1)
      is_r: begin
        B_R_Read_1           = instr[24:21];
        B_R_Read_2           = instr[20:17];
        B_R_Address_to_write = instr[28:25];
      end
      is_const: begin
        B_R_Read_1           = instr[26:23];
        B_R_Address_to_write = instr[26:23];
      end
      is_mem: begin
        B_R_Read_1           = instr[23:20];
        B_R_Read_2           = instr[27:24];
        B_R_Address_to_write = instr[27:24];
      end
      is_brr: begin
        B_R_Read_1           = instr[23:20];
        B_R_Address_to_write = instr[27:24];
      end
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an in-flight write never lands
  assign PC_Signal_write  = state == S_WB && !Signal_reset;
  assign B_R_Signal_write = state == S_WB && !Signal_reset
    && (is_r || is_const || is_load || (is_brr && instr[28]));
  assign MEM_DATA_WE      = state == S_MEM && is_store && !Signal_reset;

  assign PC_Sel = (state != S_WB) ? 2'b00
                : is_brr          ? 2'b10
                : taken           ? 2'b01
                :                   2'b00;

  assign WB_Sel = is_load                 ? 2'b01
                : (is_const && !is_addi)  ? 2'b10
                : is_brr                  ? 2'b11
                :                           2'b00;

  assign B_R_Signal_read         = state == S_DECODE;
  assign ULA_Enable              = state == S_EXEC;
  assign ULA_SrcA_Sel            = is_br;
  assign ULA_SrcB_Sel            = is_addi || is_mem || is_br;
  assign UNIDADE_CONTR_ULA_OPULA = is_r ? instr[4:0] : OPULA_ADD;
  assign EXTENSOR_DE_SINAL_IN    = instr[15:0];
  assign Halted                  = state == S_HALT;
  assign Illegal                 = illegal_q;

endmodule

// File: tb/tb_unidade_de_controle.sv
// Bench for unidade_de_controle: directed scenarios plus randomized
// instructions checked against an instruction-level timing/effect model.
module tb_unidade_de_controle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_q;
  logic        rdy;
  logic        fz, fs, fc, fv;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [3:0]  rd1, rd2, wa;
  logic        br_we, br_re;
  logic [1:0]  wb_sel;
  logic        src_a, src_b, ula_en;
  logic [4:0]  opula;
  logic [15:0] ext_in;
  logic        mem_we, halted, illegal;

  int tests = 0;
  int fails = 0;

  logic [3:0] fl_drv;
  logic [3:0] flags_m;

  // observations from one instruction
  int         o_lat, o_wr, o_we;
  logic [3:0] o_addr, o_rd1;
  logic [1:0] o_wbs, o_pcs;

  always #5 clk = ~clk;

  unidade_de_controle dut (
    .Clock_in(clk),
    .Signal_reset(rst),
    .MEM_INS_Q(ins_q),
    .ULA_OUT_Ready(rdy),
    .ULA_FLAG_Zero(fz),
    .ULA_FLAG_Signal(fs),
    .ULA_FLAG_Carry_out(fc),
    .ULA_FLAG_Overflow(fv),
    .PC_Signal_write(pc_we),
    .PC_Sel(pc_sel),
    .B_R_Read_1(rd1),
    .B_R_Read_2(rd2),
    .B_R_Address_to_write(wa),
    .B_R_Signal_write(br_we),
    .B_R_Signal_read(br_re),
    .WB_Sel(wb_sel),
    .ULA_SrcA_Sel(src_a),
    .ULA_SrcB_Sel(src_b),
    .ULA_Enable(ula_en),
    .UNIDADE_CONTR_ULA_OPULA(opula),
    .EXTENSOR_DE_SINAL_IN(ext_in),
    .MEM_DATA_WE(mem_we),
    .Halted(halted),
    .Illegal(illegal)
  );

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'd0: return f[3];
      4'd1: return !f[3];
      4'd2: return f[2];
      4'd3: return !f[2];
      4'd4: return f[1];
      4'd5: return !f[1];
      4'd6: return f[0];
      4'd7: return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: cycle count and architectural effects
  task automatic model(input logic [31:0] i, input int d,
                       output int lat, output bit wr,
                       output logic [3:0] addr, output logic [1:0] wbs,
                       output logic [1:0] pcs, output int we);
    lat = 0; wr = 0; addr = 0; wbs = 0; pcs = 0; we = 0;
    case (i[31:29])
      3'd0: begin
        lat = 4 + d; wr = 1; addr = i[28:25]; flags_m = fl_drv;
      end
      3'd1: begin
        wr = 1; addr = i[26:23];
        if (i[28:27] == 2'b10) begin
          lat = 4 + d; flags_m = fl_drv;
        end else begin
          lat = 3; wbs = 2'b10;
        end
      end
      3'd2: begin
        addr = i[27:24];
        if (i[28]) begin
          lat = 5 + d; we = 1;
        end else begin
          lat = 6 + d; wr = 1; wbs = 2'b01;
        end
      end
      3'd3: begin
        lat = 4 + d;
        pcs = (i[28] || cond_ok(i[27:24], flags_m)) ? 2'b01 : 2'b00;
      end
      3'd4: begin
        lat = 3; pcs = 2'b10; wr = i[28]; addr = i[27:24]; wbs = 2'b11;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    flags_m = 4'h0;
  endtask

  // Drives one instruction from FETCH through WB; Ready after d waits
  task automatic run_instr(input logic [31:0] i, input int d);
    int ens = 0;
    ins_q = i;
    {fz, fs, fc, fv} = fl_drv;
    o_lat = -1; o_wr = 0; o_we = 0;
    o_addr = 0; o_wbs = 0; o_pcs = 0; o_rd1 = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (br_we) begin
        o_wr++; o_addr = wa; o_wbs = wb_sel;
      end
      if (mem_we) o_we++;
      if (ula_en) begin
        rdy = (ens >= d);
        ens++;
      end else begin
        rdy = 1'b0;
      end
      if (pc_we) begin
        o_lat = cyc; o_pcs = pc_sel; o_rd1 = rd1;
        @(posedge clk);
        #1 rdy = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b0;
    ins_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    tests++;
    if ({pc_we, br_we, mem_we, halted, illegal} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 00000",
               {pc_we, br_we, mem_we, halted, illegal});
    end
    do_reset();
    tests++;
    if (ula_en !== 1'b0 || br_re !== 1'b0) begin
      fails++;
      $display("FAIL reset_fetch en=%b re=%b want 0 0", ula_en, br_re);
    end
  endtask

  task automatic test_r_add();
    fl_drv = 4'h0;
    run_instr({3'b000, 4'd3, 4'd1, 4'd2, 12'h0, 5'd0}, 0);
    tests++;
    if (o_lat !== 4 || o_wr !== 1 || o_addr !== 4'd3 || o_pcs !== 2'b00) begin
      fails++;
      $display("FAIL r_add lat=%0d wr=%0d addr=%0d pcs=%b want 4 1 3 00",
               o_lat, o_wr, o_addr, o_pcs);
    end
    tests++;
    if (o_rd1 !== 4'd1) begin
      fails++;
      $display("FAIL r_add_read1 got %0d want 1", o_rd1);
    end
  endtask

  task automatic test_load_store();
    run_instr({3'b010, 1'b0, 4'd7, 4'd5, 4'h0, 16'h0003}, 0);
    tests++;
    if (o_lat !== 6 || o_we !== 0 || o_wbs !== 2'b01 || o_wr !== 1
        || o_addr !== 4'd7) begin
      fails++;
      $display("FAIL load lat=%0d we=%0d wbs=%b wr=%0d addr=%0d want 6 0 01 1 7",
               o_lat, o_we, o_wbs, o_wr, o_addr);
    end
    run_instr({3'b010, 1'b1, 4'd4, 4'd5, 4'h0, 16'h0010}, 1);
    tests++;
    if (o_lat !== 6 || o_we !== 1 || o_wr !== 0) begin
      fails++;
      $display("FAIL store lat=%0d we=%0d wr=%0d want 6 1 0",
               o_lat, o_we, o_wr);
    end
  endtask

  task automatic test_branch();
    logic [31:0] br;
    br = {3'b011, 1'b0, 4'd0, 8'h0, 16'h0004};
    fl_drv = 4'b1000;
    run_instr({3'b000, 4'd2, 4'd1, 4'd1, 12'h0, 5'd1}, 0);
    run_instr(br, 0);
    tests++;
    if (o_lat !== 4 || o_pcs !== 2'b01 || o_wr !== 0) begin
      fails++;
      $display("FAIL branch_taken lat=%0d pcs=%b wr=%0d want 4 01 0",
               o_lat, o_pcs, o_wr);
    end
    fl_drv = 4'b0000;
    run_instr({3'b000, 4'd2, 4'd1, 4'd3, 12'h0, 5'd1}, 0);
    run_instr(br, 0);
    tests++;
    if (o_pcs !== 2'b00) begin
      fails++;
      $display("FAIL branch_not_taken pcs=%b want 00", o_pcs);
    end
    flags_m = 4'b0000;
  endtask

  task automatic test_random();
    int lat, we, d;
    bit wr;
    logic [3:0] addr;
    logic [1:0] wbs, pcs;
    logic [31:0] i;
    for (int n = 0; n < 60; n++) begin
      i = $urandom;
      i[31:29] = 3'($urandom_range(0, 4));
      if (i[31:29] == 3'd1 && i[28:27] == 2'b11) i[28] = 1'b0;
      d = $urandom_range(0, 3);
      fl_drv = 4'($urandom);
      model(i, d, lat, wr, addr, wbs, pcs, we);
      run_instr(i, d);
      tests++;
      if (o_lat !== lat || o_pcs !== pcs || o_we !== we
          || o_wr !== int'(wr)) begin
        fails++;
        $display("FAIL rand_%0d ins=%h lat=%0d/%0d pcs=%b/%b we=%0d/%0d wr=%0d/%0d",
                 n, i, o_lat, lat, o_pcs, pcs, o_we, we, o_wr, wr);
      end
      if (wr) begin
        tests++;
        if (o_addr !== addr || o_wbs !== wbs) begin
          fails++;
          $display("FAIL rand_wb_%0d ins=%h addr=%0d/%0d wbs=%b/%b",
                   n, i, o_addr, addr, o_wbs, wbs);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int hcyc = 0;
    int bad = 0;
    do_reset();
    ins_q = {3'b000, 4'd3, 4'd1, 4'd2, 12'h0, 5'd0};
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      rdy = 1'b0;
      if (pc_we || br_we || mem_we) bad++;
      if (halted && hcyc == 0) hcyc = cyc;
      @(posedge clk);
    end
    tests++;
    if (hcyc !== 11 || illegal !== 1'b1 || bad !== 0) begin
      fails++;
      $display("FAIL timeout halt_cyc=%0d ill=%b bad=%0d want 11 1 0",
               hcyc, illegal, bad);
    end
    do_reset();
    fl_drv = 4'h0;
    run_instr({3'b000, 4'd3, 4'd1, 4'd2, 12'h0, 5'd0}, 7);
    tests++;
    if (o_lat !== 11 || halted !== 1'b0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL ready_last_cycle lat=%0d h=%b ill=%b want 11 0 0",
               o_lat, halted, illegal);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] tbl [3];
    bit          ill [3];
    int hcyc, bad;
    tbl[0] = 32'hA000_0000; ill[0] = 1;
    tbl[1] = 32'hE000_0000; ill[1] = 0;
    tbl[2] = 32'h3800_0000; ill[2] = 1;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      hcyc = 0; bad = 0;
      ins_q = tbl[k];
      for (int cyc = 1; cyc <= 6; cyc++) begin
        @(negedge clk);
        if (pc_we || br_we || mem_we || ula_en) bad++;
        if (halted && hcyc == 0) hcyc = cyc;
        @(posedge clk);
      end
      tests++;
      if (hcyc !== 3 || illegal !== ill[k] || bad !== 0) begin
        fails++;
        $display("FAIL halt_%0d cyc=%0d ill=%b bad=%0d want 3 %b 0",
                 k, hcyc, illegal, bad, ill[k]);
      end
    end
    do_reset();
    tests++;
    if (illegal !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_clears ill=%b h=%b want 0 0", illegal, halted);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    ins_q = {3'b010, 1'b1, 4'd4, 4'd5, 4'h0, 16'h0001};
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      rdy = ula_en;
      @(posedge clk);
    end
    @(negedge clk);
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_store we=%b want 0", mem_we);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    flags_m = 4'h0;
    run_instr({3'b001, 2'b00, 4'd9, 7'h0, 16'h1234}, 0);
    tests++;
    if (o_lat !== 3 || o_addr !== 4'd9 || o_wbs !== 2'b10) begin
      fails++;
      $display("FAIL after_reset lat=%0d addr=%0d wbs=%b want 3 9 10",
               o_lat, o_addr, o_wbs);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; ins_q = '0;
    fz = 0; fs = 0; fc = 0; fv = 0;
    fl_drv = 4'h0; flags_m = 4'h0;
    test_reset();
    test_r_add();
    test_load_store();
    test_branch();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
